// File: rtl/al_fifo_pkg.sv
// Shared helpers for the single-clock logic FIFO: width math, ratio legality
// and the read-output register mode names.
package al_fifo_pkg;

   localparam string REGMODE_NOREG  = "NOREG";
   localparam string REGMODE_OUTREG = "OUTREG";

   function automatic int unsigned fifo_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

   function automatic int unsigned fifo_min(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   function automatic int unsigned fifo_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Wide/narrow ratio must be an exact 1, 2, 4 or 8.
   function automatic bit fifo_ratio_ok(input int unsigned w, input int unsigned r);
      int unsigned hi;
      int unsigned lo;
      int unsigned q;
      hi = fifo_max(w, r);
      lo = fifo_min(w, r);
      if (lo == 0 || (hi % lo) != 0) return 1'b0;
      q = hi / lo;
      return (q == 1) || (q == 2) || (q == 4) || (q == 8);
   endfunction

endpackage

// File: rtl/al_fifo_sdp_ram.sv
// Simple dual-port RAM addressed in storage units; the write port stores
// WR_UNITS units and the synchronous read port returns RD_UNITS units per clock.
module al_fifo_sdp_ram
   import al_fifo_pkg::*;
#(
   parameter int unsigned UNIT_W   = 8,
   parameter int unsigned N_UNITS  = 16,
   parameter int unsigned WR_UNITS = 1,
   parameter int unsigned RD_UNITS = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           we_i,
   input  logic [fifo_clog2(N_UNITS)-1:0] waddr_i,
   input  logic [WR_UNITS*UNIT_W-1:0]     wdata_i,
   input  logic                           re_i,
   input  logic [fifo_clog2(N_UNITS)-1:0] raddr_i,
   output logic [RD_UNITS*UNIT_W-1:0]     rdata_o
);

   localparam int unsigned AW   = fifo_clog2(N_UNITS);
   localparam int unsigned K    = WR_UNITS * RD_UNITS;
   localparam int unsigned CB   = fifo_clog2(K);
   localparam int unsigned ROWS = N_UNITS / K;
   localparam int unsigned WIDE = K * UNIT_W;

   logic [WIDE-1:0]            mem_q [ROWS];
   logic [RD_UNITS*UNIT_W-1:0] rdata_q;
   logic [AW-CB-1:0]           wrow;
   logic [AW-CB-1:0]           rrow;

   assign wrow    = waddr_i[AW-1:CB];
   assign rrow    = raddr_i[AW-1:CB];
   assign rdata_o = rdata_q;

   // Rows are one wide word; the narrow side selects a unit column, lowest unit first.
   if (K == 1) begin : g_same
      always_ff @(posedge clk_i) begin
         if (we_i) mem_q[wrow] <= wdata_i;
      end
      always_ff @(posedge clk_i) begin
         if (rst_i)     rdata_q <= '0;
         else if (re_i) rdata_q <= mem_q[rrow];
      end
   end else if (WR_UNITS == 1) begin : g_narrow_wr
      logic [CB-1:0] wcol;
      logic [CB-1:0] unused_rcol;
      assign wcol        = waddr_i[CB-1:0];
      assign unused_rcol = raddr_i[CB-1:0];
      always_ff @(posedge clk_i) begin
         if (we_i) mem_q[wrow][32'(wcol)*UNIT_W +: UNIT_W] <= wdata_i;
      end
      always_ff @(posedge clk_i) begin
         if (rst_i)     rdata_q <= '0;
         else if (re_i) rdata_q <= mem_q[rrow];
      end
   end else begin : g_narrow_rd
      logic [CB-1:0] rcol;
      logic [CB-1:0] unused_wcol;
      assign rcol        = raddr_i[CB-1:0];
      assign unused_wcol = waddr_i[CB-1:0];
      always_ff @(posedge clk_i) begin
         if (we_i) mem_q[wrow] <= wdata_i;
      end
      always_ff @(posedge clk_i) begin
         if (rst_i)     rdata_q <= '0;
         else if (re_i) rdata_q <= mem_q[rrow][32'(rcol)*UNIT_W +: UNIT_W];
      end
   end

endmodule

// File: rtl/al_logic_fifo_sc.sv
// Single-clock FIFO with independent write/read widths; occupancy is one
// registered unit counter from which all counts and flags are decoded.
module al_logic_fifo_sc
   import al_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_W = 9,
   parameter int unsigned DATA_WIDTH_R = DATA_WIDTH_W,
   parameter int unsigned DATA_DEPTH_W = 1024,
   parameter string       REGMODE_R    = "NOREG",
   parameter int          AE           = 6,
   parameter int          AF           = int'(DATA_DEPTH_W) - 7
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH_W-1:0]        di,
   input  logic                           we,
   input  logic                           re,
   input  logic                           ore,
   // "do" is a reserved word, hence do_o
   output logic [DATA_WIDTH_R-1:0]        do_o,
   output logic                           empty_flag,
   output logic                           aempty_flag,
   output logic                           full_flag,
   output logic                           afull_flag,
   output logic [fifo_clog2(DATA_DEPTH_W)+1-1:0] wr_count,
   output logic [fifo_clog2(DATA_DEPTH_W*DATA_WIDTH_W/DATA_WIDTH_R)+1-1:0] rd_count,
   output logic                           overflow,
   output logic                           underflow
);

   localparam int unsigned U       = fifo_min(DATA_WIDTH_W, DATA_WIDTH_R);
   localparam int unsigned WRU     = DATA_WIDTH_W / U;
   localparam int unsigned RDU     = DATA_WIDTH_R / U;
   localparam int unsigned NU      = DATA_DEPTH_W * WRU;
   localparam int unsigned DEPTH_R = NU / RDU;
   localparam int unsigned AW      = fifo_clog2(NU);
   localparam int unsigned WSH     = fifo_clog2(WRU);
   localparam int unsigned RSH     = fifo_clog2(RDU);
   localparam int unsigned WCW     = fifo_clog2(DATA_DEPTH_W) + 1;
   localparam int unsigned RCW     = fifo_clog2(DEPTH_R) + 1;

   if (!fifo_ratio_ok(DATA_WIDTH_W, DATA_WIDTH_R)) begin : g_bad_ratio
      $error("al_logic_fifo_sc: width ratio must be 1, 2, 4 or 8");
   end
   if (REGMODE_R != REGMODE_NOREG && REGMODE_R != REGMODE_OUTREG) begin : g_bad_mode
      $error("al_logic_fifo_sc: REGMODE_R must be NOREG or OUTREG");
   end

   logic [AW:0]             units_q, units_d;
   logic [AW-1:0]           wptr_q, wptr_d;
   logic [AW-1:0]           rptr_q, rptr_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic                    room, wr_ok, rd_ok;
   logic [DATA_WIDTH_R-1:0] ram_rd;

   assign wr_count    = WCW'(units_q >> WSH);
   assign rd_count    = RCW'(units_q >> RSH);
   assign full_flag   = (wr_count == WCW'(DATA_DEPTH_W));
   assign empty_flag  = (rd_count == '0);
   assign aempty_flag = (int'(rd_count) <= AE);
   assign afull_flag  = (int'(wr_count) >= AF);
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

   // With a wide write, a partial read can clear full before a whole word is free.
   assign room  = (units_q <= (AW+1)'(NU - WRU));
   assign wr_ok = we && !full_flag && room;
   assign rd_ok = re && !empty_flag;

   always_comb begin
      units_d = units_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      ovf_d   = we && !wr_ok;
      unf_d   = re && !rd_ok;
      if (wr_ok) begin
         units_d = units_d + (AW+1)'(WRU);
         wptr_d  = wptr_q + AW'(WRU);
      end
      if (rd_ok) begin
         units_d = units_d - (AW+1)'(RDU);
         rptr_d  = rptr_q + AW'(RDU);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         units_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         units_q <= units_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   al_fifo_sdp_ram #(
      .UNIT_W   (U),
      .N_UNITS  (NU),
      .WR_UNITS (WRU),
      .RD_UNITS (RDU)
   ) u_ram (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (wr_ok),
      .waddr_i (wptr_q),
      .wdata_i (di),
      .re_i    (rd_ok),
      .raddr_i (rptr_q),
      .rdata_o (ram_rd)
   );

   if (REGMODE_R == REGMODE_OUTREG) begin : g_outreg
      logic [DATA_WIDTH_R-1:0] do_q;
      always_ff @(posedge clk) begin
         if (rst)      do_q <= '0;
         else if (ore) do_q <= ram_rd;
      end
      assign do_o = do_q;
   end else begin : g_noreg
      logic unused_ore;
      assign unused_ore = ore;
      assign do_o       = ram_rd;
   end

endmodule

// File: tb/tb_al_logic_fifo_sc.sv
// Directed bench: a vector table drives an 8/8 depth-16 FIFO; short hand
// sequences cover width conversion and the OUTREG output stage.
module tb_al_logic_fifo_sc;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // A: 8/8 depth 16 NOREG
   logic [7:0] a_di = '0, a_do;
   logic a_we = 0, a_re = 0, a_empty, a_aempty, a_full, a_afull, a_ovf, a_unf;
   logic [4:0] a_wc, a_rc;
   // B: 8 -> 32 depth 16 NOREG
   logic [7:0] b_di = '0;
   logic [31:0] b_do;
   logic b_we = 0, b_re = 0, b_empty, b_aempty, b_full, b_afull, b_ovf, b_unf;
   logic [4:0] b_wc;
   logic [2:0] b_rc;
   // C: 32 -> 8 depth 4 NOREG
   logic [31:0] c_di = '0;
   logic [7:0] c_do;
   logic c_we = 0, c_re = 0, c_empty, c_aempty, c_full, c_afull, c_ovf, c_unf;
   logic [2:0] c_wc;
   logic [4:0] c_rc;
   // D: 8/8 depth 16 OUTREG
   logic [7:0] d_di = '0, d_do;
   logic d_we = 0, d_re = 0, d_ore = 1, d_empty, d_aempty, d_full, d_afull, d_ovf, d_unf;
   logic [4:0] d_wc, d_rc;

   al_logic_fifo_sc #(.DATA_WIDTH_W(8), .DATA_WIDTH_R(8), .DATA_DEPTH_W(16)) u_a (
      .clk(clk), .rst(rst), .di(a_di), .we(a_we), .re(a_re), .ore(1'b1), .do_o(a_do),
      .empty_flag(a_empty), .aempty_flag(a_aempty), .full_flag(a_full), .afull_flag(a_afull),
      .wr_count(a_wc), .rd_count(a_rc), .overflow(a_ovf), .underflow(a_unf));

   al_logic_fifo_sc #(.DATA_WIDTH_W(8), .DATA_WIDTH_R(32), .DATA_DEPTH_W(16)) u_b (
      .clk(clk), .rst(rst), .di(b_di), .we(b_we), .re(b_re), .ore(1'b1), .do_o(b_do),
      .empty_flag(b_empty), .aempty_flag(b_aempty), .full_flag(b_full), .afull_flag(b_afull),
      .wr_count(b_wc), .rd_count(b_rc), .overflow(b_ovf), .underflow(b_unf));

   al_logic_fifo_sc #(.DATA_WIDTH_W(32), .DATA_WIDTH_R(8), .DATA_DEPTH_W(4)) u_c (
      .clk(clk), .rst(rst), .di(c_di), .we(c_we), .re(c_re), .ore(1'b1), .do_o(c_do),
      .empty_flag(c_empty), .aempty_flag(c_aempty), .full_flag(c_full), .afull_flag(c_afull),
      .wr_count(c_wc), .rd_count(c_rc), .overflow(c_ovf), .underflow(c_unf));

   al_logic_fifo_sc #(.DATA_WIDTH_W(8), .DATA_WIDTH_R(8), .DATA_DEPTH_W(16),
                      .REGMODE_R("OUTREG")) u_d (
      .clk(clk), .rst(rst), .di(d_di), .we(d_we), .re(d_re), .ore(d_ore), .do_o(d_do),
      .empty_flag(d_empty), .aempty_flag(d_aempty), .full_flag(d_full), .afull_flag(d_afull),
      .wr_count(d_wc), .rd_count(d_rc), .overflow(d_ovf), .underflow(d_unf));

   typedef struct {
      logic       rst, we, re;
      logic [7:0] di;
      logic [4:0] cnt;
      logic       ovf, unf;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic w, input logic rd, input logic [7:0] d,
                               input int cnt, input logic ovf, input logic unf, input logic [7:0] dout);
      vec_t v;
      v.rst = r; v.we = w; v.re = rd; v.di = d;
      v.cnt = 5'(cnt); v.ovf = ovf; v.unf = unf; v.dout = dout;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [7:0] w2n_exp [4];

   initial begin
      // Table: fill to full, overflow, full we+re, drain, underflow, concurrent r/w, reset.
      add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
      for (int i = 0; i < 16; i++) add(0, 1, 0, 8'(i), i + 1, 0, 0, 8'h00);
      add(0, 1, 0, 8'hEE, 16, 1, 0, 8'h00);
      add(0, 0, 0, 8'h00, 16, 0, 0, 8'h00);
      add(0, 1, 1, 8'hEE, 15, 1, 0, 8'h00);
      add(0, 0, 0, 8'h00, 15, 0, 0, 8'h00);
      for (int i = 1; i < 16; i++) add(0, 0, 1, 8'h00, 15 - i, 0, 0, 8'(i));
      add(0, 0, 1, 8'h00, 0, 0, 1, 8'h0F);
      add(0, 0, 0, 8'h00, 0, 0, 0, 8'h0F);
      add(0, 1, 0, 8'hA0, 1, 0, 0, 8'h0F);
      add(0, 1, 0, 8'hA1, 2, 0, 0, 8'h0F);
      add(0, 1, 1, 8'hA2, 2, 0, 0, 8'hA0);
      add(0, 0, 1, 8'h00, 1, 0, 0, 8'hA1);
      add(0, 0, 1, 8'h00, 0, 0, 0, 8'hA2);
      for (int i = 0; i < 5; i++) add(0, 1, 0, 8'(8'h30 + i), i + 1, 0, 0, 8'hA2);
      add(1, 1, 1, 8'h99, 0, 0, 0, 8'h00);
      add(0, 1, 0, 8'h77, 1, 0, 0, 8'h00);
      add(0, 0, 1, 8'h00, 0, 0, 0, 8'h77);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; a_we = vecs[i].we; a_re = vecs[i].re; a_di = vecs[i].di;
         tick();
         chk($sformatf("v%0d empty", i),  a_empty,  vecs[i].cnt == 0);
         chk($sformatf("v%0d full", i),   a_full,   vecs[i].cnt == 16);
         chk($sformatf("v%0d aempty", i), a_aempty, vecs[i].cnt <= 6);
         chk($sformatf("v%0d afull", i),  a_afull,  vecs[i].cnt >= 9);
         chk($sformatf("v%0d wr_count", i), a_wc, vecs[i].cnt);
         chk($sformatf("v%0d rd_count", i), a_rc, vecs[i].cnt);
         chk($sformatf("v%0d overflow", i), a_ovf, vecs[i].ovf);
         chk($sformatf("v%0d underflow", i), a_unf, vecs[i].unf);
         chk($sformatf("v%0d do", i), a_do, vecs[i].dout);
      end
      rst = 0; a_we = 0; a_re = 0;

      // Narrow-to-wide: four bytes make one read word, first byte in the LSBs.
      rst = 1; tick(); rst = 0;
      chk("n2w reset empty", b_empty, 1'b1);
      b_we = 1;
      for (int i = 0; i < 3; i++) begin
         b_di = 8'h11 * 8'(i + 1);
         tick();
         chk($sformatf("n2w empty after %0d", i + 1), b_empty, 1'b1);
         chk($sformatf("n2w wr_count %0d", i + 1), b_wc, i + 1);
      end
      b_di = 8'h44; tick(); b_we = 0;
      chk("n2w empty after 4", b_empty, 1'b0);
      chk("n2w rd_count", b_rc, 1);
      b_re = 1; tick(); b_re = 0;
      chk("n2w do", b_do, 32'h44332211);
      chk("n2w empty after read", b_empty, 1'b1);
      chk("n2w wr_count after read", b_wc, 0);

      // Wide-to-narrow: least significant byte comes out first.
      w2n_exp = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      rst = 1; tick(); rst = 0;
      c_we = 1; c_di = 32'hAABBCCDD; tick(); c_we = 0;
      chk("w2n rd_count", c_rc, 4);
      chk("w2n wr_count", c_wc, 1);
      chk("w2n empty", c_empty, 1'b0);
      c_re = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("w2n do %0d", i), c_do, w2n_exp[i]);
         chk($sformatf("w2n rd_count %0d", i), c_rc, 3 - i);
      end
      tick(); c_re = 0;
      chk("w2n underflow", c_unf, 1'b1);
      chk("w2n do hold", c_do, 8'hAA);
      tick();
      chk("w2n underflow clear", c_unf, 1'b0);
      c_we = 1;
      for (int i = 0; i < 4; i++) begin
         c_di = 32'h01020304 + 32'(i);
         tick();
      end
      chk("w2n full", c_full, 1'b1);
      chk("w2n full rd_count", c_rc, 16);
      chk("w2n full wr_count", c_wc, 4);
      tick(); c_we = 0;
      chk("w2n overflow", c_ovf, 1'b1);
      chk("w2n overflow wr_count", c_wc, 4);

      // OUTREG: two-edge latency with ore=1, ore=0 freezes the output.
      d_ore = 1;
      rst = 1; tick(); rst = 0;
      chk("outreg reset do", d_do, 8'h00);
      d_we = 1; d_di = 8'h5A; tick(); d_we = 0;
      d_re = 1; tick(); d_re = 0;
      chk("outreg do one edge", d_do, 8'h00);
      tick();
      chk("outreg do two edges", d_do, 8'h5A);
      d_we = 1; d_di = 8'h6B; tick(); d_we = 0;
      d_re = 1; d_ore = 0; tick(); d_re = 0;
      chk("outreg hold a", d_do, 8'h5A);
      tick();
      chk("outreg hold b", d_do, 8'h5A);
      d_ore = 1; tick();
      chk("outreg release", d_do, 8'h6B);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
